threshold_segmenter: RTL and testbench
======================================

# threshold_segmenter

Parametrised multi-channel successor to the fixed-window threshold cutter. It accepts a stream of packed multi-channel samples and computes per-sample energy as a sum of squares. It opens a segment with hysteresis and replays a pre-trigger history from a ring buffer. It then streams live samples out on the same valid/ready/last transmit interface the PS-side AXIS path consumes, closing each segment on sustained quiet or a maximum length.

## Interface
- CHANNELS, 4, number of signed channels per sample
- SAMPLE_WIDTH, 16, bits per channel (two's complement)
- PRE_DEPTH_INDEX, 4, log2 of ring depth; PRE_DEPTH = 2**PRE_DEPTH_INDEX
- ON_THRESHOLD, 32'h0002_0000, segment opens when energy >= this
- OFF_THRESHOLD, 32'h0001_0000, a sample is quiet when energy < this; must be <= ON_THRESHOLD
- QUIET_LEN, 8, consecutive quiet live samples that close a segment (>= 1)
- MAX_LEN, 256, maximum beats per segment, including replayed history; must be > PRE_DEPTH
- LEN_WIDTH, 9, width of the segment length counter; must satisfy 2**LEN_WIDTH > MAX_LEN
- Derived: DATA_WIDTH = CHANNELS*SAMPLE_WIDTH; ENERGY_W = 2*SAMPLE_WIDTH + clog2(CHANNELS); thresholds are zero-extended or truncated to ENERGY_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- cut_en  in  1  enables triggering
- sample_vld  in  1  input sample valid
- sample_data  in  DATA_WIDTH  channel c at [c*SAMPLE_WIDTH +: SAMPLE_WIDTH]
- sample_rdy  out  1  input accept
- transmit_vld  out  1  output beat valid
- transmit_data  out  DATA_WIDTH  output sample, same packing as input
- transmit_last  out  1  final beat of segment
- transmit_rdy  in  1  downstream accept
- segment_active  out  1  high from state DRAIN until the last-beat handshake
- segment_count  out  16  completed segments; wraps at 16'hFFFF -> 0

## Operation
- Energy is the unsigned sum over channels of each signed channel squared, computed combinationally on sample_data at ENERGY_W bits with no overflow.
- Handshakes: the input transfers on sample_vld && sample_rdy; the output transfers on transmit_vld && transmit_rdy.
- The output is a single register stage. While transmit_vld && !transmit_rdy, transmit_data and transmit_last hold stable.
- States:
  - IDLE: sample_rdy=1. Each accepted sample is written to ring[wr_ptr], and wr_ptr increments mod PRE_DEPTH. fill saturates at PRE_DEPTH, and the oldest entry is overwritten when full. If cut_en=1 and energy >= ON_THRESHOLD, the trigger sample is also written as the newest entry and the state goes to DRAIN. If cut_en=0, samples are accepted and discarded, and fill is held at 0.
  - DRAIN: sample_rdy=0. Exactly fill entries are replayed oldest-first, at rd_ptr = wr_ptr - fill mod PRE_DEPTH. One entry is loaded each cycle the output register is empty or being handshaken. The length counter counts loaded beats. After the final load the state goes to LIVE. transmit_last is never set in DRAIN.
  - LIVE: sample_rdy = !transmit_vld || transmit_rdy. Each accepted sample is loaded into the output register.
    - quiet_cnt increments when energy < OFF_THRESHOLD and clears to 0 otherwise, including energies between OFF and ON.
    - The loaded beat carries transmit_last=1 if the incremented quiet_cnt equals QUIET_LEN or the incremented length equals MAX_LEN. Then the state goes to CLOSE.
  - CLOSE: sample_rdy=0. On the last-beat handshake: segment_count increments, fill, length and quiet_cnt clear, and the state goes to IDLE. A new segment therefore never replays samples from the previous one.
- If cut_en deasserts during DRAIN, LIVE or CLOSE, the segment still completes normally.

## Timing
- Reset (async assert) sets all outputs to 0, the state to IDLE, and fill, pointers, counters and segment_count to 0. sample_rdy rises in the first cycle after rst_n deasserts.
- A trigger accepted in cycle T gives DRAIN in T+1 and first transmit_vld in T+2. With transmit_rdy held 1, one beat per cycle.
- After the final drain load, sample_rdy rises in the next cycle. A live sample accepted in cycle L appears on transmit_data in L+1.
- Once the last beat is handshaken in cycle E, the state is IDLE and sample_rdy=1 in E+1.
- Reset mid-segment aborts the segment immediately. No last beat is sent and segment_count is not incremented.

## Test plan
Common parameters: defaults with PRE_DEPTH_INDEX=4, QUIET_LEN=8, MAX_LEN=64, transmit_rdy=1 unless stated.

1. Below threshold: 100 samples with all channels 16'h0010 (energy 1024) -> transmit_vld never rises; segment_count=0.
2. Normal segment: 20 samples of 16'h0010, then ch0=16'h0200 (energy 0x40000), then 8 all-zero samples -> 16 drained beats (15 history plus the trigger, oldest-first), 8 live beats, transmit_last on beat 24, segment_count=1.
3. Early trigger: reset, 3 quiet samples, then a trigger sample -> 4 drained beats; first transmit_vld 2 cycles after the trigger handshake.
4. Max length and hysteresis:
   - Sustained ch0=16'h0100 (energy 0x10000, equal to OFF, so not quiet) -> exactly 64 beats, last on beat 64.
   - A following trigger after 0 intervening samples -> 1 drained beat.
   - 7 quiet samples, then one 0x10000 sample -> quiet_cnt resets; no last beat.
5. Backpressure and cut_en: transmit_rdy alternating 1/0 -> no lost or duplicated beats, and data stable while stalled. With cut_en=0, a 0x40000 sample causes no segment and fill stays 0.
6. Reset mid-DRAIN -> all outputs 0 asynchronously. The next trigger drains only post-reset samples, and segment_count is unchanged.

Source files
------------

// File: rtl/threshold_segmenter.sv
// Energy-triggered segmenter: keeps a pre-trigger ring of samples, opens a segment with
// hysteresis, replays the history oldest-first, then streams live samples until quiet or max length.
module threshold_segmenter #(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned SAMPLE_WIDTH    = 16,
   parameter int unsigned PRE_DEPTH_INDEX = 4,
   parameter logic [31:0] ON_THRESHOLD    = 32'h0002_0000,
   parameter logic [31:0] OFF_THRESHOLD   = 32'h0001_0000,
   parameter int unsigned QUIET_LEN       = 8,
   parameter int unsigned MAX_LEN         = 256,
   parameter int unsigned LEN_WIDTH       = 9
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cut_en,
   input  logic                             sample_vld,
   input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
   output logic                             sample_rdy,
   output logic                             transmit_vld,
   output logic [CHANNELS*SAMPLE_WIDTH-1:0] transmit_data,
   output logic                             transmit_last,
   input  logic                             transmit_rdy,
   output logic                             segment_active,
   output logic [15:0]                      segment_count
);

   localparam int unsigned DATA_WIDTH = CHANNELS * SAMPLE_WIDTH;
   localparam int unsigned ENERGY_W   = 2 * SAMPLE_WIDTH + $clog2(CHANNELS);
   localparam int unsigned PRE_DEPTH  = 2 ** PRE_DEPTH_INDEX;
   localparam int unsigned QW         = $clog2(QUIET_LEN + 1);

   localparam logic [ENERGY_W-1:0]      ON_E      = ENERGY_W'(ON_THRESHOLD);
   localparam logic [ENERGY_W-1:0]      OFF_E     = ENERGY_W'(OFF_THRESHOLD);
   localparam logic [QW-1:0]            QUIET_END = QW'(QUIET_LEN);
   localparam logic [LEN_WIDTH-1:0]     LEN_END   = LEN_WIDTH'(MAX_LEN);
   localparam logic [PRE_DEPTH_INDEX:0] FILL_FULL = {1'b1, {PRE_DEPTH_INDEX{1'b0}}};

   typedef enum logic [1:0] {IDLE, DRAIN, LIVE, CLOSE} state_e;

   state_e                     state_q;
   logic                       up_q;
   logic [DATA_WIDTH-1:0]      ring_q [PRE_DEPTH];
   logic [PRE_DEPTH_INDEX-1:0] wr_ptr_q, rd_ptr_q;
   logic [PRE_DEPTH_INDEX:0]   fill_q, fill_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [QW-1:0]              quiet_q, quiet_d;
   logic                       tvld_q, tlast_q, active_q;
   logic [DATA_WIDTH-1:0]      tdata_q;
   logic [15:0]                seg_cnt_q;

   logic [ENERGY_W-1:0]             energy;
   logic signed [SAMPLE_WIDTH-1:0]  chan;
   logic signed [2*SAMPLE_WIDTH-1:0] square;
   logic out_free, in_fire, ring_wr, trigger, last_d;

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      energy = '0;
      chan   = '0;
      square = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         chan   = sample_data[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         square = chan * chan;
         energy = energy + ENERGY_W'($unsigned(square));
      end
   end

   // up_q keeps sample_rdy low while reset is held and for the edge that releases it
   assign out_free   = !tvld_q || transmit_rdy;
   assign sample_rdy = (state_q == IDLE) ? up_q : ((state_q == LIVE) && out_free);
   assign in_fire    = sample_vld && sample_rdy;
   assign ring_wr    = in_fire && (state_q == IDLE) && cut_en;
   assign trigger    = ring_wr && (energy >= ON_E);

   assign fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
   assign len_d   = len_q + 1'b1;
   assign quiet_d = (energy < OFF_E) ? quiet_q + 1'b1 : '0;
   assign last_d  = (quiet_d == QUIET_END) || (len_d == LEN_END);

   // NOTE: the history ring is plain storage and carries no reset; fill_q alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (ring_wr) ring_q[wr_ptr_q] <= sample_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         up_q      <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         len_q     <= '0;
         quiet_q   <= '0;
         tvld_q    <= 1'b0;
         tlast_q   <= 1'b0;
         tdata_q   <= '0;
         active_q  <= 1'b0;
         seg_cnt_q <= '0;
      end else begin
         up_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (!cut_en) begin
                  fill_q <= '0;
               end else if (ring_wr) begin
                  wr_ptr_q <= wr_ptr_q + 1'b1;
                  fill_q   <= fill_d;
                  if (trigger) begin
                     // oldest valid entry, counted back from the slot after the trigger
                     rd_ptr_q <= wr_ptr_q + 1'b1 - fill_d[PRE_DEPTH_INDEX-1:0];
                     active_q <= 1'b1;
                     state_q  <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_free) begin
                  tvld_q   <= 1'b1;
                  tdata_q  <= ring_q[rd_ptr_q];
                  tlast_q  <= 1'b0;
                  rd_ptr_q <= rd_ptr_q + 1'b1;
                  len_q    <= len_d;
                  if (len_d == LEN_WIDTH'(fill_q)) state_q <= LIVE;
               end
            end
            LIVE: begin
               if (in_fire) begin
                  tvld_q  <= 1'b1;
                  tdata_q <= sample_data;
                  tlast_q <= last_d;
                  len_q   <= len_d;
                  quiet_q <= quiet_d;
                  if (last_d) state_q <= CLOSE;
               end else if (transmit_rdy) begin
                  tvld_q <= 1'b0;
               end
            end
            CLOSE: begin
               if (tvld_q && transmit_rdy) begin
                  tvld_q    <= 1'b0;
                  tlast_q   <= 1'b0;
                  seg_cnt_q <= seg_cnt_q + 1'b1;
                  fill_q    <= '0;
                  len_q     <= '0;
                  quiet_q   <= '0;
                  active_q  <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign transmit_vld   = tvld_q;
   assign transmit_data  = tdata_q;
   assign transmit_last  = tlast_q;
   assign segment_active = active_q;
   assign segment_count  = seg_cnt_q;

endmodule

// File: tb/tb_threshold_segmenter.sv
// Directed bench for threshold_segmenter: a reference model queues every expected output beat
// as samples are accepted, and a monitor compares beats (including stalled ones) as they appear.
module tb_threshold_segmenter;

   localparam longint ON  = 64'h2_0000;
   localparam longint OFF = 64'h1_0000;
   localparam logic [63:0] ZERO  = 64'h0;
   localparam logic [63:0] LOW   = 64'h0010_0010_0010_0010;
   localparam logic [63:0] TRIG  = 64'h0000_0000_0000_0200;
   localparam logic [63:0] NTRIG = 64'h0000_0000_0000_FE00;
   localparam logic [63:0] EDGE  = 64'h0000_0000_0100_0100;
   localparam logic [63:0] MID   = 64'h0000_0000_0000_0100;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cut_en = 1'b1;
   logic        sample_vld = 1'b0;
   logic [63:0] sample_data = '0;
   logic        sample_rdy;
   logic        transmit_vld;
   logic [63:0] transmit_data;
   logic        transmit_last;
   logic        transmit_rdy = 1'b1;
   logic        segment_active;
   logic [15:0] segment_count;

   int    n_vec = 0;
   int    n_err = 0;
   int    seg_beats = 0;
   bit    bp_mode = 0;
   beat_t exp_q[$];
   logic [63:0] hist[$];
   bit    m_live = 0;
   int    m_len = 0;
   int    m_quiet = 0;

   threshold_segmenter #(
      .CHANNELS(4), .SAMPLE_WIDTH(16), .PRE_DEPTH_INDEX(4),
      .ON_THRESHOLD(32'h0002_0000), .OFF_THRESHOLD(32'h0001_0000),
      .QUIET_LEN(8), .MAX_LEN(64), .LEN_WIDTH(9)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cut_en(cut_en),
      .sample_vld(sample_vld), .sample_data(sample_data), .sample_rdy(sample_rdy),
      .transmit_vld(transmit_vld), .transmit_data(transmit_data),
      .transmit_last(transmit_last), .transmit_rdy(transmit_rdy),
      .segment_active(segment_active), .segment_count(segment_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (bp_mode) transmit_rdy = ~transmit_rdy;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic longint energy_of(input logic [63:0] d);
      longint e, s;
      e = 0;
      for (int c = 0; c < 4; c++) begin
         s = longint'($signed(d[c*16 +: 16]));
         e += s * s;
      end
      return e;
   endfunction

   // Beats are compared at the falling edge; a stalled beat must keep matching the queue head.
   always @(negedge clk) begin
      if (rst_n && transmit_vld) begin
         check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            check("beat_data", transmit_data, exp_q[0].data);
            check("beat_last", 64'(transmit_last), 64'(exp_q[0].last));
            if (transmit_rdy) begin
               void'(exp_q.pop_front());
               seg_beats++;
            end
         end
      end
   end

   task automatic model_accept(input logic [63:0] d);
      longint e;
      beat_t  b;
      bit     last;
      e = energy_of(d);
      if (!m_live) begin
         if (!cut_en) begin
            hist.delete();
         end else begin
            hist.push_back(d);
            if (hist.size() > 16) void'(hist.pop_front());
            if (e >= ON) begin
               foreach (hist[i]) begin
                  b.data = hist[i];
                  b.last = 1'b0;
                  exp_q.push_back(b);
               end
               m_len   = hist.size();
               m_quiet = 0;
               m_live  = 1;
               hist.delete();
            end
         end
      end else begin
         m_len++;
         m_quiet = (e < OFF) ? m_quiet + 1 : 0;
         last    = (m_quiet == 8) || (m_len == 64);
         b.data  = d;
         b.last  = last;
         exp_q.push_back(b);
         if (last) m_live = 0;
      end
   endtask

   task automatic send(input logic [63:0] d);
      int n;
      n = 0;
      sample_vld  = 1'b1;
      sample_data = d;
      @(negedge clk);
      while (!sample_rdy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("sample_rdy_wait", 64'(sample_rdy), 64'd1);
      if (sample_rdy) model_accept(d);
      @(posedge clk);
      #1;
      sample_vld = 1'b0;
   endtask

   task automatic wait_close(input string tag, input int exp_cnt, input int exp_beats);
      int n;
      n = 0;
      @(negedge clk);
      while (!(transmit_vld && transmit_rdy && transmit_last) && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_last_seen"}, 64'(transmit_vld && transmit_rdy && transmit_last), 64'd1);
      @(posedge clk);
      #1;
      check({tag, "_rdy_after"}, 64'(sample_rdy), 64'd1);
      check({tag, "_active_after"}, 64'(segment_active), 64'd0);
      check({tag, "_count"}, 64'(segment_count), 64'(exp_cnt));
      check({tag, "_beats"}, 64'(seg_beats), 64'(exp_beats));
      check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      seg_beats = 0;
   endtask

   task automatic do_reset(input string tag);
      rst_n      = 1'b0;
      sample_vld = 1'b0;
      #1;
      check({tag, "_vld"}, 64'(transmit_vld), 64'd0);
      check({tag, "_last"}, 64'(transmit_last), 64'd0);
      check({tag, "_data"}, transmit_data, 64'd0);
      check({tag, "_rdy"}, 64'(sample_rdy), 64'd0);
      check({tag, "_active"}, 64'(segment_active), 64'd0);
      check({tag, "_count"}, 64'(segment_count), 64'd0);
      exp_q.delete();
      hist.delete();
      m_live    = 0;
      m_len     = 0;
      m_quiet   = 0;
      seg_beats = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check({tag, "_rdy_held"}, 64'(sample_rdy), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_rdy_rise"}, 64'(sample_rdy), 64'd1);
   endtask

   initial begin
      #3;
      do_reset("reset0");

      // 1: sub-threshold stream never opens a segment
      for (int i = 0; i < 100; i++) send(LOW);
      check("t1_count", 64'(segment_count), 64'd0);
      check("t1_active", 64'(segment_active), 64'd0);

      // 2: full history replay, then quiet close
      for (int i = 0; i < 20; i++) send(LOW);
      send(TRIG);
      for (int i = 0; i < 8; i++) send(ZERO);
      wait_close("t2", 1, 24);

      // 3: short history, negative trigger channel, first-beat latency
      do_reset("reset3");
      send(64'h0001_0001_0001_0001);
      send(64'h0002_0002_0002_0002);
      send(64'hFFFF_0003_0003_0003);
      send(NTRIG);
      check("t3_vld_T1", 64'(transmit_vld), 64'd0);
      check("t3_active_T1", 64'(segment_active), 64'd1);
      check("t3_rdy_T1", 64'(sample_rdy), 64'd0);
      @(posedge clk);
      #1;
      check("t3_vld_T2", 64'(transmit_vld), 64'd1);
      for (int i = 0; i < 8; i++) send(ZERO);
      wait_close("t3", 1, 12);

      // 4: trigger at exactly ON, then energy == OFF keeps the segment open to MAX_LEN
      for (int i = 1; i <= 5; i++) send(64'(i) * 64'h0000_0001_0001_0001);
      send(EDGE);
      for (int i = 0; i < 100 && m_live; i++) send(MID);
      wait_close("t4a", 2, 64);
      send(TRIG);
      for (int i = 0; i < 7; i++) send(ZERO);
      send(MID);
      for (int i = 0; i < 8; i++) send(ZERO);
      wait_close("t4b", 3, 17);

      // 5: alternating backpressure, then cut_en low suppresses triggering and history
      bp_mode = 1;
      send(64'h1111_0001_0002_0003);
      send(64'h0004_0005_0006_0007);
      send(64'h0008_0009_000A_000B);
      send(64'hFFF0_FFF1_FFF2_FFF3);
      send(TRIG);
      for (int i = 0; i < 8; i++) send(ZERO);
      wait_close("t5a", 4, 13);
      bp_mode      = 0;
      transmit_rdy = 1'b1;
      cut_en       = 1'b0;
      send(LOW);
      send(TRIG);
      send(LOW);
      @(posedge clk);
      #1;
      check("t5_cut_vld", 64'(transmit_vld), 64'd0);
      check("t5_cut_active", 64'(segment_active), 64'd0);
      check("t5_cut_count", 64'(segment_count), 64'd4);
      cut_en = 1'b1;
      send(TRIG);
      for (int i = 0; i < 8; i++) send(ZERO);
      wait_close("t5b", 5, 9);

      // 6: reset in the middle of a drain
      for (int i = 0; i < 10; i++) send(64'(i + 1) * 64'h0001_0000_0000_0001);
      send(TRIG);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      do_reset("reset6");
      send(64'h0000_0000_0042_0042);
      send(64'h0000_0000_0043_0043);
      send(TRIG);
      for (int i = 0; i < 8; i++) send(ZERO);
      wait_close("t6", 1, 11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
